frame_arbiter: RTL and testbench

FRAME_ARBITER -- requirements
Module: frame_arbiter

---
 rtl/frame_arbiter.sv | 148 ++++++++++++++
 tb/tb_frame_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_arbiter.sv
// Round-robin frame arbiter: grants one input per frame and forwards its beats
// through a single registered output stage with one-cycle latency.
module frame_arbiter #(
    parameter int unsigned NumInputs = 2,
    parameter int unsigned DataWidth = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NumInputs-1:0]           en_mask,
    input  logic [NumInputs-1:0]           din_valid,
    output logic [NumInputs-1:0]           din_ready,
    input  logic [NumInputs-1:0]           din_eof,
    input  logic [NumInputs*DataWidth-1:0] din_data,
    input  logic                           dout_ready,
    output logic                           dout_valid,
    output logic                           dout_eof,
    output logic [DataWidth-1:0]           dout_data,
    output logic [1:0]                     dout_id,
    output logic                           busy
);

    localparam int unsigned IdxW = 2;

    typedef enum logic {
        IDLE = 1'b0,
        FWD  = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       grant_q, grant_d;
    logic [IdxW-1:0]       ptr_q, ptr_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  dout_eof_q, dout_eof_d;
    logic [DataWidth-1:0]  dout_data_q, dout_data_d;
    logic [IdxW-1:0]       dout_id_q, dout_id_d;

    logic [NumInputs-1:0]  req;
    logic                  pick_found;
    logic [IdxW-1:0]       pick_idx;
    logic [IdxW-1:0]       cand;
    logic                  g_valid;
    logic                  g_eof;
    logic [DataWidth-1:0]  g_data;
    logic                  out_free;
    logic                  accept;
    logic [IdxW-1:0]       ptr_next;

    assign req      = din_valid & en_mask;
    assign out_free = ~dout_valid_q | dout_ready;
    assign ptr_next = (grant_q == IdxW'(NumInputs - 1)) ? '0 : grant_q + IdxW'(1);

    // Rotating priority search starting at ptr; masked requesters are skipped.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 0; k < NumInputs; k++) begin
            cand = IdxW'((32'(ptr_q) + k) % NumInputs);
            for (int unsigned i = 0; i < NumInputs; i++) begin
                if (!pick_found && (cand == IdxW'(i)) && req[i]) begin
                    pick_found = 1'b1;
                    pick_idx   = cand;
                end
            end
        end
    end

    // Granted input's handshake and payload; all other inputs are ignored.
    always_comb begin
        g_valid   = 1'b0;
        g_eof     = 1'b0;
        g_data    = '0;
        din_ready = '0;
        for (int unsigned i = 0; i < NumInputs; i++) begin
            if (grant_q == IdxW'(i)) begin
                g_valid      = din_valid[i];
                g_eof        = din_eof[i];
                g_data       = din_data[i*DataWidth +: DataWidth];
                din_ready[i] = (state_q == FWD) && out_free;
            end
        end
    end

    assign accept = (state_q == FWD) && g_valid && out_free;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        ptr_d        = ptr_q;
        dout_valid_d = dout_valid_q;
        dout_eof_d   = dout_eof_q;
        dout_data_d  = dout_data_q;
        dout_id_d    = dout_id_q;

        if (dout_valid_q && dout_ready) begin
            dout_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = FWD;
                end
            end
            FWD: begin
                if (accept) begin
                    dout_valid_d = 1'b1;
                    dout_eof_d   = g_eof;
                    dout_data_d  = g_data;
                    dout_id_d    = grant_q;
                    if (g_eof) begin
                        state_d = IDLE;
                        ptr_d   = ptr_next;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            ptr_q        <= '0;
            dout_valid_q <= 1'b0;
            dout_eof_q   <= 1'b0;
            dout_data_q  <= '0;
            dout_id_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            ptr_q        <= ptr_d;
            dout_valid_q <= dout_valid_d;
            dout_eof_q   <= dout_eof_d;
            dout_data_q  <= dout_data_d;
            dout_id_q    <= dout_id_d;
        end
    end

    assign dout_valid = dout_valid_q;
    assign dout_eof   = dout_eof_q;
    assign dout_data  = dout_data_q;
    assign dout_id    = dout_id_q;
    assign busy       = (state_q == FWD);

endmodule

// File: tb/tb_frame_arbiter.sv
// Bench for frame_arbiter: arbitration vector table plus scoreboard-checked frame sequences.
module tb_frame_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  en_mask;
    logic [N-1:0]  din_valid;
    logic [N-1:0]  din_ready;
    logic [N-1:0]  din_eof;
    logic [N*DW-1:0] din_data;
    logic          dout_ready;
    logic          dout_valid;
    logic          dout_eof;
    logic [DW-1:0] dout_data;
    logic [1:0]    dout_id;
    logic          busy;

    frame_arbiter #(.NumInputs(N), .DataWidth(DW)) dut (
        .clk(clk), .rst(rst), .en_mask(en_mask), .din_valid(din_valid),
        .din_ready(din_ready), .din_eof(din_eof), .din_data(din_data),
        .dout_ready(dout_ready), .dout_valid(dout_valid), .dout_eof(dout_eof),
        .dout_data(dout_data), .dout_id(dout_id), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] data; logic eof; } beat_t;
    typedef struct packed { logic [7:0] data; logic eof; logic [1:0] id; } exp_t;
    typedef struct packed { logic [1:0] mask; logic [1:0] valid; logic [1:0] ready; logic busy; } vec_t;

    beat_t src0[$];
    beat_t src1[$];
    exp_t  sb[$];
    logic [1:0] gate;
    int checks = 0;
    int errors = 0;
    logic       stall_prev;
    logic [7:0] stall_data;
    logic       stall_eof;
    logic [1:0] stall_id;
    logic       eof_acc_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_src(input int src, input logic [7:0] base, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = base + 8'(k);
            b.eof  = (k == len - 1);
            if (src == 0) src0.push_back(b); else src1.push_back(b);
        end
    endtask

    task automatic add_exp(input logic [1:0] id, input logic [7:0] base, input int len);
        exp_t e;
        for (int k = 0; k < len; k++) begin
            e.data = base + 8'(k);
            e.eof  = (k == len - 1);
            e.id   = id;
            sb.push_back(e);
        end
    endtask

    // One clock: drive at negedge, observe before the edge, retire accepted beats.
    task automatic step();
        beat_t b0, b1;
        exp_t  e;
        logic [1:0] acc;
        logic oxfer;
        b0 = '0;
        b1 = '0;
        if (src0.size() > 0) b0 = src0[0];
        if (src1.size() > 0) b1 = src1[0];
        din_valid = {gate[1] && (src1.size() > 0), gate[0] && (src0.size() > 0)};
        din_data  = {b1.data, b0.data};
        din_eof   = {b1.eof, b0.eof};
        #1;
        acc   = din_valid & din_ready;
        oxfer = dout_valid & dout_ready;
        check("ready_onehot", 32'($countones(din_ready) <= 1), 32'd1);
        if (eof_acc_prev) check("eof_gap", 32'(acc), 32'd0);
        if (stall_prev)
            check("stall_hold", 32'({dout_valid, dout_eof, dout_id, dout_data}),
                  32'({1'b1, stall_eof, stall_id, stall_data}));
        if (dout_valid && !dout_ready) check("stall_ready", 32'(din_ready), 32'd0);
        if (oxfer) begin
            if (sb.size() == 0) begin
                check("unexpected_beat", 32'({dout_id, dout_data}), 32'hFFFF);
            end else begin
                e = sb.pop_front();
                check("dout_beat", 32'({dout_eof, dout_id, dout_data}), 32'({e.eof, e.id, e.data}));
            end
        end
        stall_prev   = dout_valid && !dout_ready;
        stall_data   = dout_data;
        stall_eof    = dout_eof;
        stall_id     = dout_id;
        eof_acc_prev = |(acc & din_eof);
        @(posedge clk);
        if (acc[0]) void'(src0.pop_front());
        if (acc[1]) void'(src1.pop_front());
        @(negedge clk);
    endtask

    task automatic clear_bench();
        src0.delete();
        src1.delete();
        sb.delete();
        stall_prev   = 1'b0;
        eof_acc_prev = 1'b0;
        din_valid    = '0;
        din_eof      = '0;
        din_data     = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_bench();
        #1;
        check("reset_outs", 32'({dout_valid, dout_eof, dout_id, dout_data, din_ready, busy}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            step();
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    vec_t vecs[7];

    initial begin
        int n;
        rst = 1'b0;
        en_mask = '0;
        dout_ready = 1'b1;
        gate = 2'b11;
        clear_bench();

        // Arbitration from reset (ptr=0): {mask, valid} -> din_ready, busy one cycle later.
        vecs[0] = '{2'b11, 2'b11, 2'b01, 1'b1};
        vecs[1] = '{2'b11, 2'b10, 2'b10, 1'b1};
        vecs[2] = '{2'b01, 2'b10, 2'b00, 1'b0};
        vecs[3] = '{2'b10, 2'b11, 2'b10, 1'b1};
        vecs[4] = '{2'b00, 2'b11, 2'b00, 1'b0};
        vecs[5] = '{2'b11, 2'b01, 2'b01, 1'b1};
        vecs[6] = '{2'b11, 2'b00, 2'b00, 1'b0};
        for (int v = 0; v < 7; v++) begin
            do_reset();
            en_mask    = vecs[v].mask;
            din_valid  = vecs[v].valid;
            din_eof    = 2'b11;
            din_data   = {8'hB5, 8'hA5};
            dout_ready = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_ready", v), 32'(din_ready), 32'(vecs[v].ready));
            check($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].busy));
            @(negedge clk);
        end

        // Two 3-beat frames, first output two cycles after din_valid.
        do_reset();
        en_mask = 2'b11; gate = 2'b11; dout_ready = 1'b1;
        add_src(0, 8'hA0, 3); add_src(1, 8'hB0, 3);
        add_exp(2'd0, 8'hA0, 3); add_exp(2'd1, 8'hB0, 3);
        n = 0;
        while (!dout_valid && n < 10) begin step(); n++; end
        check("first_latency", 32'(n), 32'd2);
        drain(100);

        // Continuous 2-beat frames on both inputs alternate grants.
        do_reset();
        for (int f = 0; f < 3; f++) begin
            add_src(0, 8'h10 + 8'(2*f), 2);
            add_src(1, 8'h20 + 8'(2*f), 2);
            add_exp(2'd0, 8'h10 + 8'(2*f), 2);
            add_exp(2'd1, 8'h20 + 8'(2*f), 2);
        end
        drain(100);

        // Downstream stall for 4 cycles mid-frame.
        do_reset();
        add_src(0, 8'hC0, 4); add_exp(2'd0, 8'hC0, 4);
        n = 0;
        while (sb.size() > 0 && n < 60) begin
            dout_ready = !(n >= 4 && n < 8);
            step();
            n++;
        end
        check("stall_drain", 32'(sb.size()), 32'd0);
        dout_ready = 1'b1;

        // Masked input skipped; later granted frame survives valid/mask drop.
        do_reset();
        en_mask = 2'b01;
        add_src(0, 8'h40, 2); add_src(1, 8'h50, 3);
        add_exp(2'd0, 8'h40, 2);
        drain(50);
        repeat (3) step();
        check("masked_skip", 32'(src1.size()), 32'd3);
        en_mask = 2'b11;
        add_exp(2'd1, 8'h50, 3);
        n = 0;
        while (src1.size() == 3 && n < 20) begin step(); n++; end
        check("masked_grant_start", 32'(src1.size()), 32'd2);
        gate[1] = 1'b0;
        en_mask = 2'b01;
        add_src(0, 8'h60, 2); add_exp(2'd0, 8'h60, 2);
        for (int k = 0; k < 5; k++) begin
            step();
            check("hold_busy", 32'(busy), 32'd1);
        end
        check("hold_no_steal", 32'(src0.size()), 32'd2);
        gate[1] = 1'b1;
        drain(100);

        // Back-to-back single-beat frames: one IDLE cycle between each.
        do_reset();
        en_mask = 2'b11;
        for (int f = 0; f < 4; f++) begin
            add_src(0, 8'hD0 + 8'(f), 1);
            add_exp(2'd0, 8'hD0 + 8'(f), 1);
        end
        n = 0;
        while (sb.size() > 0 && n < 60) begin step(); n++; end
        check("single_beat_cycles", 32'(n), 32'd9);

        // Reset during beat 2 of a 4-beat frame; restart favours input 0.
        do_reset();
        add_src(0, 8'hE0, 4); add_exp(2'd0, 8'hE0, 4);
        n = 0;
        while (src0.size() > 2 && n < 20) begin step(); n++; end
        rst = 1'b0;
        #1;
        check("midframe_reset_outs",
              32'({dout_valid, dout_eof, dout_id, dout_data, din_ready, busy}), 32'd0);
        clear_bench();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        add_src(1, 8'hF0, 2); add_src(0, 8'h70, 2);
        add_exp(2'd0, 8'h70, 2); add_exp(2'd1, 8'hF0, 2);
        drain(100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
